ps2_dir_decoder: RTL and testbench

Converts the raw PS/2 byte stream into Pacman direction events for the processor. It sits between the PS/2 interface and the processor. Each received scan-code byte arrives as ps2_key_data with a one-cycle ps2_key_pressed strobe. The block decodes make, break and extended (E0) sequences for the arrow keys and WASD, tracks which directions are held, and queues direction events in a first-word-fall-through FIFO that the processor pops.

---
 rtl/ps2_dir_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_dir_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dir_decoder.sv
// PS/2 scan-code decoder for arrow/WASD keys: tracks held directions and
// queues make/break direction events in a first-word-fall-through FIFO.
module ps2_dir_decoder #(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ps2_key_pressed,
  input  logic [7:0]    ps2_key_data,
  input  logic          rd_en,
  input  logic          clear_ovf,
  output logic [2:0]    evt_data,
  output logic          evt_empty,
  output logic          evt_full,
  output logic [CW-1:0] evt_count,
  output logic          evt_overflow,
  output logic [3:0]    held,
  output logic [1:0]    cur_dir
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t state_reg, state_next;

  logic          wasd_hit, arrow_hit;
  logic [1:0]    wasd_dir, arrow_dir;
  logic          make_done, brk_done;
  logic [1:0]    evt_dir;
  logic          push_req, push_ok, pop;
  logic [2:0]    push_word;

  logic [3:0]    held_reg, held_next;
  logic [1:0]    cur_dir_reg, cur_dir_next;
  logic          ovf_reg, ovf_next;

  logic [2:0]    mem_reg [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] wr_sel;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;

  always_comb begin
    wasd_hit = 1'b1;
    wasd_dir = 2'd0;
    case (ps2_key_data)
      8'h1D:   wasd_dir = 2'd0;
      8'h1B:   wasd_dir = 2'd1;
      8'h1C:   wasd_dir = 2'd2;
      8'h23:   wasd_dir = 2'd3;
      default: wasd_hit = 1'b0;
    endcase
  end

  always_comb begin
    arrow_hit = 1'b1;
    arrow_dir = 2'd0;
    case (ps2_key_data)
      8'h75:   arrow_dir = 2'd0;
      8'h72:   arrow_dir = 2'd1;
      8'h6B:   arrow_dir = 2'd2;
      8'h74:   arrow_dir = 2'd3;
      default: arrow_hit = 1'b0;
    endcase
  end

  // Decoder only moves on strobe cycles; every non-prefix byte ends a sequence.
  always_comb begin
    state_next = state_reg;
    make_done  = 1'b0;
    brk_done   = 1'b0;
    evt_dir    = 2'd0;
    if (ps2_key_pressed) begin
      case (state_reg)
        S_IDLE: begin
          if (ps2_key_data == 8'hE0) begin
            state_next = S_EXT;
          end else if (ps2_key_data == 8'hF0) begin
            state_next = S_BRK;
          end else if (wasd_hit) begin
            make_done = 1'b1;
            evt_dir   = wasd_dir;
          end
        end
        S_EXT: begin
          state_next = S_IDLE;
          if (ps2_key_data == 8'hF0) begin
            state_next = S_EXT_BRK;
          end else if (arrow_hit) begin
            make_done = 1'b1;
            evt_dir   = arrow_dir;
          end
        end
        S_BRK: begin
          state_next = S_IDLE;
          if (wasd_hit) begin
            brk_done = 1'b1;
            evt_dir  = wasd_dir;
          end
        end
        S_EXT_BRK: begin
          state_next = S_IDLE;
          if (arrow_hit) begin
            brk_done = 1'b1;
            evt_dir  = arrow_dir;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Typematic repeats and breaks of unheld keys are filtered by the held mask.
  assign push_req  = (make_done && !held_reg[evt_dir]) || (brk_done && held_reg[evt_dir]);
  assign push_word = {make_done, evt_dir};

  for (genvar gi = 0; gi < 4; gi++) begin : g_held
    always_comb begin
      held_next[gi] = held_reg[gi];
      if (evt_dir == 2'(gi)) begin
        if (make_done) begin
          held_next[gi] = 1'b1;
        end else if (brk_done) begin
          held_next[gi] = 1'b0;
        end
      end
    end
  end

  assign cur_dir_next = (make_done && !held_reg[evt_dir]) ? evt_dir : cur_dir_reg;

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign pop     = rd_en && (count_reg != '0);
  assign push_ok = push_req && ((count_reg < DEPTH_C) || pop);
  assign ovf_next = (push_req && !push_ok) ? 1'b1 :
                    clear_ovf              ? 1'b0 : ovf_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = push_ok && (wr_ptr_reg == AW'(gi));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_reg[i] <= push_word;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      held_reg    <= 4'b0000;
      cur_dir_reg <= 2'd0;
      ovf_reg     <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      held_reg    <= held_next;
      cur_dir_reg <= cur_dir_next;
      ovf_reg     <= ovf_next;
      count_reg   <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  assign evt_data     = (count_reg == '0) ? 3'b000 : mem_reg[rd_ptr_reg];
  assign evt_empty    = (count_reg == '0);
  assign evt_full     = (count_reg == DEPTH_C);
  assign evt_count    = count_reg;
  assign evt_overflow = ovf_reg;
  assign held         = held_reg;
  assign cur_dir      = cur_dir_reg;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Self-checking bench for ps2_dir_decoder: directed scenarios plus a random
// byte stream compared against a sequence-level reference model.
module tb_ps2_dir_decoder;

  localparam int D = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [2:0] evt_data;
  logic       evt_empty, evt_full, evt_overflow;
  logic [3:0] evt_count;
  logic [3:0] held;
  logic [1:0] cur_dir;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [2:0] m_q[$];
  logic [7:0] m_pre[$];
  logic [3:0] m_held;
  logic [1:0] m_cur;
  logic       m_ovf;

  ps2_dir_decoder #(.FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .ps2_key_pressed(ps2_key_pressed), .ps2_key_data(ps2_key_data),
    .rd_en(rd_en), .clear_ovf(clear_ovf),
    .evt_data(evt_data), .evt_empty(evt_empty), .evt_full(evt_full),
    .evt_count(evt_count), .evt_overflow(evt_overflow),
    .held(held), .cur_dir(cur_dir)
  );

  always #5 clock = ~clock;

  function automatic int wasd_dir(input logic [7:0] b);
    case (b)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int arrow_dir(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_pre.delete();
    m_held = 4'b0000;
    m_cur  = 2'd0;
    m_ovf  = 1'b0;
  endtask

  // Applies one cycle's inputs to the model; prefix bytes are kept as a list.
  task automatic model_step(input logic pk, input logic [7:0] b, input logic rd, input logic clr);
    int d = -1;
    bit mk = 1'b0;
    bit ev_valid = 1'b0;
    bit dropped = 1'b0;
    logic [2:0] ev = 3'b000;
    if (pk) begin
      if (m_pre.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) m_pre.push_back(b);
        else begin
          d  = wasd_dir(b);
          mk = 1'b1;
        end
      end else if (m_pre.size() == 1 && m_pre[0] == 8'hE0 && b == 8'hF0) begin
        m_pre.push_back(b);
      end else begin
        mk = (m_pre[m_pre.size()-1] != 8'hF0);
        d  = (m_pre[0] == 8'hE0) ? arrow_dir(b) : wasd_dir(b);
        m_pre.delete();
      end
      if (d >= 0) begin
        if (mk && !m_held[d]) begin
          m_held[d] = 1'b1;
          m_cur     = 2'(d);
          ev_valid  = 1'b1;
          ev        = {1'b1, 2'(d)};
        end else if (!mk && m_held[d]) begin
          m_held[d] = 1'b0;
          ev_valid  = 1'b1;
          ev        = {1'b0, 2'(d)};
        end
      end
    end
    if (rd && m_q.size() > 0) begin
      $display("pop  evt=%b", m_q[0]);
      void'(m_q.pop_front());
    end
    if (ev_valid) begin
      if (m_q.size() < D) begin
        m_q.push_back(ev);
        $display("push evt=%b", ev);
      end else begin
        dropped = 1'b1;
        $display("drop evt=%b", ev);
      end
    end
    m_ovf = dropped ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  task automatic cycle(input logic pk, input logic [7:0] b, input logic rd, input logic clr);
    ps2_key_pressed = pk;
    ps2_key_data    = b;
    rd_en           = rd;
    clear_ovf       = clr;
    model_step(pk, b, rd, clr);
    @(posedge clock);
    #1;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    rd_en           = 1'b0;
    clear_ovf       = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    total++; if (evt_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", evt_empty); end
    total++; if (evt_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
    total++; if (evt_data !== 3'b000) begin bad++; $display("FAIL reset_data: got %b expected 000", evt_data); end
    total++; if (held !== 4'b0000 || cur_dir !== 2'd0) begin bad++; $display("FAIL reset_held_dir: got %b/%b expected 0000/00", held, cur_dir); end
    total++; if (evt_full !== 1'b0 || evt_overflow !== 1'b0) begin bad++; $display("FAIL reset_full_ovf: got %b/%b expected 0/0", evt_full, evt_overflow); end
  endtask

  task automatic test_ext_make();
    send(8'hE0);
    send(8'h75);
    total++; if (evt_data !== 3'b100) begin bad++; $display("FAIL ext_make_data: got %b expected 100", evt_data); end
    total++; if (held !== 4'b0001) begin bad++; $display("FAIL ext_make_held: got %b expected 0001", held); end
    total++; if (cur_dir !== 2'd0 || evt_count !== 4'd1) begin bad++; $display("FAIL ext_make_dir_count: got %b/%0d expected 00/1", cur_dir, evt_count); end
  endtask

  task automatic test_repeat_break();
    send(8'hE0); send(8'h75);
    total++; if (evt_count !== 4'd1) begin bad++; $display("FAIL repeat_no_push: got %0d expected 1", evt_count); end
    send(8'hE0); send(8'hF0); send(8'h75);
    total++; if (evt_count !== 4'd2 || held !== 4'b0000) begin bad++; $display("FAIL break_push: got %0d/%b expected 2/0000", evt_count, held); end
    total++; if (evt_data !== 3'b100) begin bad++; $display("FAIL break_head: got %b expected 100", evt_data); end
    pop_one();
    total++; if (evt_data !== 3'b000 || evt_empty !== 1'b0) begin bad++; $display("FAIL pop1: got %b/%b expected 000/0", evt_data, evt_empty); end
    pop_one();
    total++; if (evt_empty !== 1'b1 || evt_count !== 4'd0) begin bad++; $display("FAIL pop2: got %b/%0d expected 1/0", evt_empty, evt_count); end
  endtask

  task automatic test_wasd_ignored_break();
    do_reset();
    send(8'h1C);
    send(8'hF0); send(8'h23);
    total++; if (evt_count !== 4'd1 || evt_data !== 3'b110) begin bad++; $display("FAIL wasd_make: got %0d/%b expected 1/110", evt_count, evt_data); end
    total++; if (cur_dir !== 2'b10 || held !== 4'b0100) begin bad++; $display("FAIL wasd_state: got %b/%b expected 10/0100", cur_dir, held); end
  endtask

  // Nine distinct events: four makes, four breaks, then a fresh make.
  task automatic fill_bytes(input int n);
    logic [7:0] seq [13];
    seq = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hF0, 8'h1D, 8'hF0, 8'h1B,
            8'hF0, 8'h1C, 8'hF0, 8'h23, 8'h1D};
    for (int i = 0; i < n; i++) send(seq[i]);
  endtask

  task automatic test_overflow();
    logic [2:0] exp_ev [8];
    exp_ev = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011};
    do_reset();
    fill_bytes(13);
    total++; if (evt_full !== 1'b1 || evt_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flags: got %b/%b expected 1/1", evt_full, evt_overflow); end
    total++; if (evt_count !== 4'd8 || held !== 4'b0001) begin bad++; $display("FAIL ovf_count_held: got %0d/%b expected 8/0001", evt_count, held); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (evt_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b expected 0", evt_overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (evt_data !== exp_ev[i]) begin bad++; $display("FAIL ovf_drain[%0d]: got %b expected %b", i, evt_data, exp_ev[i]); end
      pop_one();
    end
    total++; if (evt_empty !== 1'b1) begin bad++; $display("FAIL ovf_drained: got %b expected 1", evt_empty); end
  endtask

  task automatic test_full_push_pop();
    logic [2:0] exp_ev [8];
    exp_ev = '{3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    do_reset();
    fill_bytes(12);
    cycle(1'b1, 8'h1D, 1'b1, 1'b0);
    total++; if (evt_count !== 4'd8 || evt_overflow !== 1'b0) begin bad++; $display("FAIL full_pushpop: got %0d/%b expected 8/0", evt_count, evt_overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (evt_data !== exp_ev[i]) begin bad++; $display("FAIL full_drain[%0d]: got %b expected %b", i, evt_data, exp_ev[i]); end
      pop_one();
    end
  endtask

  task automatic test_reset_mid_seq();
    do_reset();
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h75);
    total++; if (evt_count !== 4'd0 || held !== 4'b0000) begin bad++; $display("FAIL midreset: got %0d/%b expected 0/0000", evt_count, held); end
    send(8'hE1); send(8'h5A);
    send(8'hE0); send(8'hE0); send(8'h75);
    total++; if (evt_count !== 4'd0) begin bad++; $display("FAIL unknown_bytes: got %0d expected 0", evt_count); end
    send(8'h1D);
    total++; if (evt_count !== 4'd1 || evt_data !== 3'b100) begin bad++; $display("FAIL idle_after: got %0d/%b expected 1/100", evt_count, evt_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pool [12];
    logic [7:0] b;
    logic [2:0] exp_head;
    int k;
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
             8'h75, 8'h72, 8'h6B, 8'h74, 8'hE1, 8'h5A};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 12));
      b = (k == 12) ? 8'($urandom) : pool[k];
      cycle(($urandom_range(0, 9) < 8), b, ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0));
      exp_head = (m_q.size() > 0) ? m_q[0] : 3'b000;
      total++; if (evt_count !== 4'(m_q.size())) begin bad++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, evt_count, m_q.size()); end
      total++; if (evt_data !== exp_head) begin bad++; $display("FAIL rnd_data@%0d: got %b expected %b", n, evt_data, exp_head); end
      total++; if (held !== m_held || cur_dir !== m_cur) begin bad++; $display("FAIL rnd_held_dir@%0d: got %b/%b expected %b/%b", n, held, cur_dir, m_held, m_cur); end
      total++; if (evt_overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %b expected %b", n, evt_overflow, m_ovf); end
      total++; if (evt_empty !== (m_q.size() == 0) || evt_full !== (m_q.size() == D)) begin bad++; $display("FAIL rnd_flags@%0d: got %b/%b expected %b/%b", n, evt_empty, evt_full, m_q.size() == 0, m_q.size() == D); end
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_ext_make();
    test_repeat_break();
    test_wasd_ignored_break();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_seq();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
